aer_core_event_merger: RTL and testbench

- Second-generation multi-core AER output merger.
- Collects output events from CORE_NUM core FIFOs and forwards neuron events with true round-robin fairness, skipping idle cores.
- Enforces a timestep barrier: one merged timestep event is emitted only after every enabled core has reached its timestep boundary.
- Sits between the core array output FIFOs and the next-layer AER input, behind a registered valid/ready output stage.

---
 rtl/aer_core_event_merger.sv | 159 +++++++++++++++
 tb/tb_aer_core_event_merger.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_core_event_merger.sv
// Round-robin merge of per-core AER FIFOs into one stream with a timestep barrier across enabled cores.
// Latency: head to evt_req is 1 cycle; cores are popped only while the output slot is free (empty or being accepted).
module aer_core_event_merger #(
    parameter int CORE_NUM                 = 16,
    parameter int AER_OUT_CORE_WIDTH       = 8,
    parameter int CORE_ID_W                = $clog2(CORE_NUM),
    parameter int AER_OUT_NEXT_LAYER_WIDTH = AER_OUT_CORE_WIDTH + CORE_ID_W,
    parameter int BARRIER_TIMEOUT          = 1024,
    parameter int CNT_W                    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [CORE_NUM-1:0]                    core_en,
    input  logic [CORE_NUM-1:0]                    core_req,
    input  logic [CORE_NUM*AER_OUT_CORE_WIDTH-1:0] core_addr,
    output logic [CORE_NUM-1:0]                    core_ack,
    output logic                                   evt_req,
    output logic [AER_OUT_NEXT_LAYER_WIDTH-1:0]    evt_addr,
    input  logic                                   evt_ack,
    output logic [CNT_W-1:0]                       tstep_cnt,
    output logic [CNT_W-1:0]                       step_evt_cnt,
    output logic                                   barrier_stall,
    input  logic                                   stall_clr
);

    localparam int W    = AER_OUT_CORE_WIDTH;
    localparam int TO_W = $clog2(BARRIER_TIMEOUT + 1);
    localparam logic [CORE_ID_W:0] CORE_NUM_W = (CORE_ID_W + 1)'(CORE_NUM);
    localparam logic [TO_W-1:0]    TO_MAX     = TO_W'(BARRIER_TIMEOUT);
    localparam logic [1:0]         TYPE_TSTEP = 2'b01;

    typedef enum logic [1:0] {IDLE, NEUR, TSTEP} state_t;

    state_t                state, state_nxt;
    logic                  active;
    logic [CORE_ID_W-1:0]  ptr;
    logic [CNT_W-1:0]      run_cnt;
    logic [TO_W-1:0]       to_cnt;

    logic [CORE_NUM-1:0]   neur_cand, parked;
    logic                  gnt_found;
    logic [CORE_ID_W-1:0]  gnt_id;
    logic [W-1:0]          gnt_dat;
    logic [CORE_ID_W:0]    sum;
    logic [W-3:0]          low_id;
    logic [1:0]            ty;
    logic                  slot_free, do_grant, do_release;

    always_comb begin
        neur_cand = '0;
        parked    = '0;
        ty        = '0;
        for (int i = 0; i < CORE_NUM; i++) begin
            ty           = core_addr[i*W + W - 2 +: 2];
            neur_cand[i] = core_en[i] & core_req[i] & (ty != TYPE_TSTEP);
            parked[i]    = core_en[i] & core_req[i] & (ty == TYPE_TSTEP);
        end
    end

    // Search starts one past the last granted core so every active core gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_dat   = '0;
        sum       = '0;
        for (int k = 1; k <= CORE_NUM; k++) begin
            sum = {1'b0, ptr} + (CORE_ID_W + 1)'(k);
            if (sum >= CORE_NUM_W)
                sum = sum - CORE_NUM_W;
            if (!gnt_found && neur_cand[sum[CORE_ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = sum[CORE_ID_W-1:0];
                gnt_dat   = core_addr[sum[CORE_ID_W-1:0]*W +: W];
            end
        end
    end

    always_comb begin
        low_id = '0;
        for (int i = CORE_NUM - 1; i >= 0; i--)
            if (core_en[i])
                low_id = core_addr[i*W +: W-2];
    end

    assign slot_free  = (state == IDLE) || evt_ack;
    assign do_grant   = active && slot_free && gnt_found;
    assign do_release = active && slot_free && !gnt_found && (core_en != '0) && (parked == core_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (do_grant)
            state_nxt = NEUR;
        else if (do_release)
            state_nxt = TSTEP;
        else if (slot_free)
            state_nxt = IDLE;
    end

    always_comb begin
        evt_req  = (state != IDLE);
        core_ack = '0;
        if (do_grant)
            core_ack = CORE_NUM'(1) << gnt_id;
        else if (do_release)
            core_ack = core_en;
    end

    // active holds off pops for the first cycle out of reset so core_ack is quiet while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active       <= 1'b0;
            evt_addr     <= '0;
            ptr          <= CORE_ID_W'(CORE_NUM - 1);
            run_cnt      <= '0;
            step_evt_cnt <= '0;
            tstep_cnt    <= '0;
        end else begin
            active <= 1'b1;
            if (do_grant) begin
                evt_addr <= {gnt_dat, gnt_id};
                ptr      <= gnt_id;
                if (run_cnt != '1)
                    run_cnt <= run_cnt + 1'b1;
            end else if (do_release) begin
                evt_addr     <= {TYPE_TSTEP, low_id, CORE_ID_W'(0)};
                ptr          <= CORE_ID_W'(CORE_NUM - 1);
                step_evt_cnt <= run_cnt;
                run_cnt      <= '0;
                tstep_cnt    <= tstep_cnt + 1'b1;
            end
        end
    end

    // Counter saturates at the limit; the flag is set once on the cycle the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt        <= '0;
            barrier_stall <= 1'b0;
        end else begin
            if (do_release || (parked == '0))
                to_cnt <= '0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + 1'b1;

            if ((parked != '0) && !do_release && (to_cnt == TO_MAX - TO_W'(1)))
                barrier_stall <= 1'b1;
            else if (stall_clr)
                barrier_stall <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aer_core_event_merger.sv
// Randomized and directed bench for aer_core_event_merger against a queue-based reference model.
module tb_aer_core_event_merger;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;
    localparam int OW  = W + IDW;
    localparam int TO  = 8;
    localparam int CW  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    core_en = '0;
    logic [N-1:0]    core_req = '0;
    logic [N*W-1:0]  core_addr = '0;
    logic [N-1:0]    core_ack;
    logic            evt_req;
    logic [OW-1:0]   evt_addr;
    logic            evt_ack = 1'b0;
    logic [CW-1:0]   tstep_cnt, step_evt_cnt;
    logic            barrier_stall;
    logic            stall_clr = 1'b0;

    always #5 clk = ~clk;

    aer_core_event_merger #(
        .CORE_NUM(N), .AER_OUT_CORE_WIDTH(W), .BARRIER_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .core_en(core_en), .core_req(core_req),
        .core_addr(core_addr), .core_ack(core_ack), .evt_req(evt_req),
        .evt_addr(evt_addr), .evt_ack(evt_ack), .tstep_cnt(tstep_cnt),
        .step_evt_cnt(step_evt_cnt), .barrier_stall(barrier_stall), .stall_clr(stall_clr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state: per-core FIFO contents plus the observable merger state.
    logic [W-1:0]  q[N][$];
    logic [N-1:0]  ack_log[$];
    int            ack_mode;   // 0 random, 1 always ready, 2 never ready
    logic [N-1:0]  en_val;
    logic          clr_val;
    bit            m_vld, m_stall;
    logic [OW-1:0] m_addr;
    int            m_ptr, m_run, m_tcnt, m_step, m_to;

    function automatic logic [W-1:0] ev(input int t, input int id);
        return {2'(t), (W-2)'(id)};
    endfunction

    task automatic model_reset();
        m_vld = 0; m_addr = '0; m_ptr = N - 1; m_run = 0;
        m_tcnt = 0; m_step = 0; m_to = 0; m_stall = 0;
        for (int i = 0; i < N; i++) q[i].delete();
        ack_log.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_evt_req", 32'(evt_req), 0);
        check("rst_core_ack", 32'(core_ack), 0);
        check("rst_evt_addr", 32'(evt_addr), 0);
        check("rst_tstep_cnt", 32'(tstep_cnt), 0);
        check("rst_step_evt_cnt", 32'(step_evt_cnt), 0);
        check("rst_stall", 32'(barrier_stall), 0);
        model_reset();
        core_req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle();
        logic [N-1:0] cand, park, exp_ack;
        logic [W-1:0] h;
        int g, lo;
        bit free, rel;
        @(negedge clk);
        core_en   = en_val;
        stall_clr = clr_val;
        evt_ack   = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        cand = '0; park = '0;
        for (int i = 0; i < N; i++) begin
            h = (q[i].size() > 0) ? q[i][0] : '0;
            core_req[i] = (q[i].size() > 0);
            core_addr[i*W +: W] = h;
            if (q[i].size() > 0 && en_val[i]) begin
                if (h[W-1:W-2] == 2'b01) park[i] = 1'b1;
                else                      cand[i] = 1'b1;
            end
        end
        #1;
        free = !m_vld || evt_ack;
        g = -1;
        if (free)
            for (int k = 1; k <= N; k++)
                if (g < 0 && cand[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        rel = free && (g < 0) && (en_val != '0) && (park == en_val);
        exp_ack = (g >= 0) ? (N'(1) << g) : rel ? en_val : '0;

        check("core_ack", 32'(core_ack), 32'(exp_ack));
        check("evt_req", 32'(evt_req), 32'(m_vld));
        if (m_vld) check("evt_addr", 32'(evt_addr), 32'(m_addr));
        check("tstep_cnt", 32'(tstep_cnt), 32'(m_tcnt));
        check("step_evt_cnt", 32'(step_evt_cnt), 32'(m_step));
        check("barrier_stall", 32'(barrier_stall), 32'(m_stall));
        if (core_ack != '0) ack_log.push_back(core_ack);

        if (g >= 0) begin
            m_addr = {q[g][0], IDW'(g)};
            m_vld  = 1; m_ptr = g;
            if (m_run < 65535) m_run++;
            void'(q[g].pop_front());
        end else if (rel) begin
            lo = N;
            for (int i = N - 1; i >= 0; i--) if (en_val[i]) lo = i;
            h = q[lo][0];
            m_addr = {2'b01, h[W-3:0], IDW'(0)};
            m_vld  = 1; m_step = m_run; m_run = 0;
            m_tcnt = (m_tcnt + 1) % 65536; m_ptr = N - 1;
            for (int i = 0; i < N; i++) if (en_val[i]) void'(q[i].pop_front());
        end else if (free) begin
            m_vld = 0;
        end

        if (park != '0 && !rel) begin
            if (m_to < TO) begin
                m_to++;
                if (m_to == TO) m_stall = 1;
                else if (clr_val) m_stall = 0;
            end else if (clr_val) m_stall = 0;
        end else begin
            m_to = 0;
            if (clr_val) m_stall = 0;
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic refill();
        int n, t;
        for (int i = 0; i < N; i++) begin
            n = $urandom_range(0, 3);
            for (int e = 0; e < n; e++) begin
                t = $urandom_range(0, 2);
                q[i].push_back(ev((t == 0) ? 0 : t + 1, $urandom_range(0, 63)));
            end
            q[i].push_back(ev(1, $urandom_range(0, 63)));
        end
    endtask

    initial begin
        en_val = 4'hF; clr_val = 1'b0; ack_mode = 1;

        // Cores 0,2,3 each one neuron event
        do_reset();
        q[0].push_back(ev(0, 1)); q[2].push_back(ev(2, 2)); q[3].push_back(ev(3, 3));
        run(5);
        check("s1_n_acks", ack_log.size(), 3);
        if (ack_log.size() == 3) begin
            check("s1_ack0", 32'(ack_log[0]), 1);
            check("s1_ack1", 32'(ack_log[1]), 4);
            check("s1_ack2", 32'(ack_log[2]), 8);
        end

        // Fairness: core1 x3, core2 x1 gives 1,2,1,1
        do_reset();
        for (int e = 0; e < 3; e++) q[1].push_back(ev(0, 10 + e));
        q[2].push_back(ev(2, 20));
        run(6);
        check("s2_n_acks", ack_log.size(), 4);
        if (ack_log.size() == 4) begin
            check("s2_ack0", 32'(ack_log[0]), 2);
            check("s2_ack1", 32'(ack_log[1]), 4);
            check("s2_ack2", 32'(ack_log[2]), 2);
            check("s2_ack3", 32'(ack_log[3]), 2);
        end

        // 7 neuron events, then all cores at timestep id 5
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int e = 0; e < ((i == 3) ? 1 : 2); e++) q[i].push_back(ev(2, i * 4 + e));
            q[i].push_back(ev(1, 5));
        end
        run(12);
        check("s3_step_evt_cnt", 32'(step_evt_cnt), 7);
        check("s3_tstep_cnt", 32'(tstep_cnt), 1);
        check("s3_n_acks", ack_log.size(), 8);
        if (ack_log.size() > 0) check("s3_release", 32'(ack_log[ack_log.size()-1]), 32'hF);

        // Cores 0-2 parked while core 3 drains three neuron events
        do_reset();
        for (int i = 0; i < 3; i++) q[i].push_back(ev(1, 3));
        for (int e = 0; e < 3; e++) q[3].push_back(ev(0, 40 + e));
        q[3].push_back(ev(1, 3));
        run(8);
        check("s4_n_acks", ack_log.size(), 4);
        if (ack_log.size() == 4) begin
            check("s4_ack0", 32'(ack_log[0]), 8);
            check("s4_ack2", 32'(ack_log[2]), 8);
            check("s4_ack3", 32'(ack_log[3]), 32'hF);
        end

        // Backpressure: event held for 10 cycles with no pops
        do_reset();
        q[1].push_back(ev(0, 7)); q[1].push_back(ev(3, 8));
        ack_mode = 2;
        run(11);
        check("s5_n_acks", ack_log.size(), 1);

        // Reset while an event is pending, then barrier timeout
        do_reset();
        ack_mode = 1;
        for (int i = 0; i < 3; i++) q[i].push_back(ev(1, 9));
        run(8);
        check("s6_stall_before", 32'(barrier_stall), 0);
        run(1);
        check("s6_stall_set", 32'(barrier_stall), 1);
        en_val = 4'b0111;
        run(1);
        if (ack_log.size() > 0) check("s6_release", 32'(ack_log[ack_log.size()-1]), 32'h7);
        else check("s6_release", 0, 32'h7);
        clr_val = 1'b1;
        run(1);
        clr_val = 1'b0;
        run(1);
        check("s6_stall_clr", 32'(barrier_stall), 0);

        // Randomized traffic with enable changes, stall clears and random backpressure
        do_reset();
        en_val = 4'hF; ack_mode = 0;
        for (int c = 0; c < 800; c++) begin
            if (q[0].size() + q[1].size() + q[2].size() + q[3].size() < 3) refill();
            if ($urandom_range(0, 49) == 0)
                en_val = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            clr_val = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
